dsp_sample_mem: RTL and testbench

DSP_SAMPLE_MEM -- requirements
Module: dsp_sample_mem

---
 rtl/dsp_sample_mem.sv | 139 +++++++++++++
 tb/tb_dsp_sample_mem.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_sample_mem.sv
// dsp_sample_mem: Wishbone B3 slave RAM holding DSP samples.
// Define DSP_SAMPLE_MEM_BURST_EN for incrementing/wrapping bursts.
module dsp_sample_mem #(
  parameter int          dw           = 32,
  parameter int          aw           = 32,
  parameter int          MEM_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [dw-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam logic [aw-1:0] BASE = aw'(BASE_ADDRESS);
  localparam logic [aw-1:0] SPAN = aw'(4 * MEM_WORDS);

`ifdef DSP_SAMPLE_MEM_BURST_EN
  typedef enum logic [1:0] {IDLE, CLASSIC, BURST} state_t;
`else
  typedef enum logic [1:0] {IDLE, CLASSIC} state_t;
`endif

  logic [dw-1:0] mem [MEM_WORDS];
  logic [dw-1:0] rd_q;
  logic [IW-1:0] rd_idx;
  state_t        state_q, state_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          req;

  // Borrow bit of the extended subtraction flags addresses below BASE.
  function automatic logic hit(input logic [aw-1:0] a);
    logic [aw:0] d;
    d = {1'b0, a} - {1'b0, BASE};
    return !d[aw] && (d[aw-1:0] < SPAN);
  endfunction

  function automatic logic [IW-1:0] widx(input logic [aw-1:0] a);
    return IW'((a - BASE) >> 2);
  endfunction

  assign req      = wb_cyc_i & wb_stb_i;
  assign wb_ack_o = ack_q & req;
  assign wb_err_o = err_q & req;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = wb_ack_o ? rd_q : '0;

`ifdef DSP_SAMPLE_MEM_BURST_EN
  logic [aw-1:0] baddr_q, baddr_d, nxt, wrap_m;

  always_comb begin
    unique case (wb_bte_i)
      2'b01:   wrap_m = aw'(32'h0C);
      2'b10:   wrap_m = aw'(32'h1C);
      2'b11:   wrap_m = aw'(32'h3C);
      default: wrap_m = '1;
    endcase
    nxt = (baddr_q & ~wrap_m) | ((baddr_q + aw'(4)) & wrap_m);
  end

  always_ff @(posedge wb_clk or posedge wb_rst)
    if (wb_rst) baddr_q <= '0;
    else        baddr_q <= baddr_d;
`else
  logic unused_ok;
  assign unused_ok = ^{wb_cti_i, wb_bte_i};
`endif

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rd_idx  = widx(wb_adr_i);
`ifdef DSP_SAMPLE_MEM_BURST_EN
    baddr_d = baddr_q;
`endif
    unique case (state_q)
      IDLE: if (req) begin
        ack_d   = hit(wb_adr_i);
        err_d   = ~hit(wb_adr_i);
        state_d = CLASSIC;
`ifdef DSP_SAMPLE_MEM_BURST_EN
        if (wb_cti_i == 3'b010) begin
          state_d = BURST;
          baddr_d = wb_adr_i;
        end
`endif
      end
      CLASSIC: state_d = IDLE;
`ifdef DSP_SAMPLE_MEM_BURST_EN
      // Prefetch the predicted beat so data is ready in its ack cycle.
      BURST: begin
        state_d = IDLE;
        if (wb_ack_o && wb_cti_i != 3'b111) begin
          state_d = BURST;
          baddr_d = nxt;
          rd_idx  = widx(nxt);
          ack_d   = hit(nxt);
          err_d   = ~hit(nxt);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst)
    if (wb_rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end

  always_ff @(posedge wb_clk)
    rd_q <= mem[rd_idx];

  always_ff @(posedge wb_clk)
    if (wb_ack_o && wb_we_i)
      for (int b = 0; b < dw / 8; b++)
        if (wb_sel_i[b])
          mem[widx(wb_adr_i)][8*b +: 8] <= wb_dat_i[8*b +: 8];

endmodule

// File: tb/tb_dsp_sample_mem.sv
// tb_dsp_sample_mem: scoreboard bench for the Wishbone sample RAM.
// Burst scenarios run only with DSP_SAMPLE_MEM_BURST_EN defined.
`timescale 1ns/1ps
module tb_dsp_sample_mem;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WORDS = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [31:0] rdat;
  logic        ack, err, rty;

  dsp_sample_mem #(
    .dw(32), .aw(32), .MEM_WORDS(WORDS), .BASE_ADDRESS(BASE)
  ) dut (
    .wb_clk(clk), .wb_rst(rst),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(rdat), .wb_ack_o(ack),
    .wb_err_o(err), .wb_rty_o(rty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic        chk_dat;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [WORDS];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wa(input int w);
    return BASE + 32'(w) * 32'd4;
  endfunction

  function automatic logic in_mem(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * WORDS));
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] nxt(input logic [31:0] a,
                                      input logic [1:0] t);
    logic [31:0] span;
    if (t == 2'b00) return a + 32'd4;
    span = 32'd8 << t;
    return (a / span) * span + ((a + 32'd4) % span);
  endfunction

  function automatic exp_t mk(input logic [31:0] a, input logic w);
    exp_t e;
    e.ack     = in_mem(a);
    e.err     = !e.ack;
    e.chk_dat = !(e.ack && w);
    e.dat     = (e.ack && !w) ? model[idx(a)] : 32'h0;
    return e;
  endfunction

  task automatic sb_check(input string tag, input logic commit,
                          output logic was_err);
    exp_t e;
    was_err = 1'b1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(ack | err), 32'h0);
      return;
    end
    e = sb.pop_front();
    was_err = e.err;
    chk({tag, "_ack"}, 32'(ack), 32'(e.ack));
    chk({tag, "_err"}, 32'(err), 32'(e.err));
    if (e.chk_dat) chk({tag, "_dat"}, rdat, e.dat);
    if (commit && e.ack && we)
      for (int b = 0; b < 4; b++)
        if (sel[b]) model[idx(adr)][8*b +: 8] = wdat[8*b +: 8];
  endtask

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
  endtask

  task automatic xfer(input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [2:0] c);
    logic e_err;
    @(posedge clk); #1;
    adr = a; we = w; wdat = d; sel = s; cti = c; bte = 2'b00;
    cyc = 1'b1; stb = 1'b1;
    sb.push_back(mk(a, w));
    @(negedge clk);
    chk("cl_wait", 32'({ack, err}), 32'h0);
    @(negedge clk);
    sb_check("classic", 1'b1, e_err);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    chk("cl_one_cycle", 32'({ack, err}), 32'h0);
  endtask

`ifdef DSP_SAMPLE_MEM_BURST_EN
  task automatic burst(input int w0, input int n, input logic [1:0] t,
                       input logic w, input int abort);
    logic [31:0] a;
    logic        e_err;
    a = wa(w0);
    @(posedge clk); #1;
    adr = a; we = w; wdat = 32'hA500_0000; sel = 4'hF; bte = t;
    cti = 3'b010; cyc = 1'b1; stb = 1'b1;
    sb.push_back(mk(a, w));
    @(negedge clk);
    chk("b_wait", 32'({ack, err}), 32'h0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sb_check("beat", i != abort, e_err);
      if (i == abort) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_dat", rdat, 32'h0);
        @(posedge clk); #1;
        idle_bus();
        rst = 1'b0;
        sb.delete();
        return;
      end
      @(posedge clk); #1;
      if (e_err || i == n - 1) break;
      a = nxt(a, t);
      adr = a;
      wdat = 32'hA500_0000 | 32'(i + 1);
      cti = (i + 1 == n - 1) ? 3'b111 : 3'b010;
      sb.push_back(mk(a, w));
    end
    // Bus stays up one more cycle: a finished burst must not ack again.
    @(negedge clk);
    chk("b_tail", 32'({ack, err}), 32'h0);
    @(posedge clk); #1;
    idle_bus();
    @(posedge clk);
  endtask
`else
  task automatic held(input int w0);
    logic e_err;
    @(posedge clk); #1;
    adr = wa(w0); we = 1'b0; sel = 4'hF; cti = 3'b010; bte = 2'b00;
    cyc = 1'b1; stb = 1'b1;
    sb.push_back(mk(adr, 1'b0));
    sb.push_back(mk(adr, 1'b0));
    @(negedge clk);
    chk("h_wait", 32'({ack, err}), 32'h0);
    @(negedge clk);
    sb_check("held1", 1'b1, e_err);
    @(negedge clk);
    chk("h_gap", 32'({ack, err}), 32'h0);
    @(negedge clk);
    sb_check("held2", 1'b1, e_err);
    @(posedge clk); #1;
    idle_bus();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ack0", 32'(ack), 32'h0);
    chk("rst_err0", 32'(err), 32'h0);
    chk("rst_dat0", rdat, 32'h0);
    chk("rty0", 32'(rty), 32'h0);
    rst = 1'b0;

    xfer(wa(5), 1'b1, 32'hDEADBEEF, 4'hF, 3'b000);
    xfer(wa(5), 1'b0, 32'h0, 4'hF, 3'b000);
    xfer(wa(9), 1'b1, 32'h11223344, 4'hF, 3'b000);
    xfer(wa(9), 1'b1, 32'hAABBCCDD, 4'b0101, 3'b000);
    xfer(wa(9), 1'b0, 32'h0, 4'hF, 3'b000);

    xfer(wa(WORDS), 1'b0, 32'h0, 4'hF, 3'b000);
    xfer(BASE - 32'd4, 1'b1, 32'h5555_5555, 4'hF, 3'b000);

    for (int k = 0; k < 8; k++)
      xfer(wa(k), 1'b1, 32'(k), 4'hF, 3'b000);
    for (int k = WORDS - 2; k < WORDS; k++)
      xfer(wa(k), 1'b1, 32'hC0DE_0000 | 32'(k), 4'hF, 3'b000);

`ifdef DSP_SAMPLE_MEM_BURST_EN
    burst(0, 4, 2'b00, 1'b0, -1);
    burst(6, 4, 2'b01, 1'b0, -1);
    burst(5, 8, 2'b10, 1'b0, -1);
    burst(WORDS - 2, 4, 2'b00, 1'b0, -1);
    burst(0, 8, 2'b00, 1'b1, 2);
    for (int k = 0; k < 8; k++)
      xfer(wa(k), 1'b0, 32'h0, 4'hF, 3'b000);
`else
    xfer(wa(3), 1'b0, 32'h0, 4'hF, 3'b010);
    held(6);
`endif

    xfer(wa(WORDS - 1), 1'b0, 32'h0, 4'hF, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
